// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: drains bytes from the UART receiver with a two-state
// rdy/rdy_clr handshake and buffers them in a first-word-fall-through FIFO.
// Bytes arriving while the FIFO is full are dropped and flagged in a sticky
// overrun bit.
module uart_rx_fifo #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_rdy,
    output logic              rx_rdy_clr,
    output logic [7:0]        dout,
    output logic              valid,
    input  logic              ready,
    output logic [ADDR_W:0]   count,
    output logic              overrun,
    input  logic              ovr_clr
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE   = 1;
    localparam logic [ADDR_W-1:0] PTR_ONE   = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } cap_state_t;

    cap_state_t        state;
    cap_state_t        state_next;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   count_next;
    logic              valid_q;
    logic              overrun_q;
    logic              capture;
    logic              full;
    logic              pop;
    logic              push;
    logic              drop;

    // Handshake decode: a byte is taken only from IDLE, and the ACK cycle
    // ignores rx_rdy because the receiver is still clearing it.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rx_rdy) begin
                    capture    = 1'b1;
                    state_next = ST_ACK;
                end
            end
            ST_ACK: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Handshake state register; the ACK state doubles as the rdy_clr pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign rx_rdy_clr = (state == ST_ACK);

    assign full = (count_q == DEPTH_CNT);
    assign pop  = valid_q && ready;
    assign push = capture && (!full || pop);
    assign drop = capture && full && !pop;

    // Occupancy is unchanged when a push and pop coincide, including when full.
    always_comb begin
        count_next = count_q;
        case ({push, pop})
            2'b10:   count_next = count_q + CNT_ONE;
            2'b01:   count_next = count_q - CNT_ONE;
            default: count_next = count_q;
        endcase
    end

    // Pointers, occupancy and the registered non-empty flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count_q <= count_next;
            valid_q <= (count_next != '0);
        end
    end

    // Sticky overrun; a new drop outranks a simultaneous clear request.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else if (drop) begin
            overrun_q <= 1'b1;
        end else if (ovr_clr) begin
            overrun_q <= 1'b0;
        end
    end

    // Storage array; contents need no reset since valid gates dout.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    assign dout    = mem[rd_ptr];
    assign valid   = valid_q;
    assign count   = count_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scenario tasks drive the receiver handshake and consumer
// side; accepted bytes go into a scoreboard queue and are compared as they
// are popped from the DUT.
module tb_uart_rx_fifo;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        rx_data;
    logic              rx_rdy;
    logic              rx_rdy_clr;
    logic [7:0]        dout;
    logic              valid;
    logic              ready;
    logic [ADDR_W:0]   count;
    logic              overrun;
    logic              ovr_clr;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];

    uart_rx_fifo #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_rdy     (rx_rdy),
        .rx_rdy_clr (rx_rdy_clr),
        .dout       (dout),
        .valid      (valid),
        .ready      (ready),
        .count      (count),
        .overrun    (overrun),
        .ovr_clr    (ovr_clr)
    );

    // 10 ns clock; stimulus changes and sampling both happen on the falling edge.
    always #5 clk = ~clk;

    // Present a byte from an idle handshake, hold rx_rdy through the ACK edge,
    // and confirm a single rdy_clr pulse.
    task automatic send_byte(input logic [7:0] b, input bit accept);
        rx_data = b;
        rx_rdy  = 1'b1;
        @(negedge clk);
        checks++;
        if (rx_rdy_clr !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ack_high byte %h: rx_rdy_clr=%b expected 1", b, rx_rdy_clr);
        end
        if (accept) exp_q.push_back(b);
        @(negedge clk);
        checks++;
        if (rx_rdy_clr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ack_low byte %h: rx_rdy_clr=%b expected 0", b, rx_rdy_clr);
        end
        rx_rdy = 1'b0;
    endtask

    // Pop one byte and compare it against the scoreboard head.
    task automatic pop_one();
        logic [7:0] exp;
        checks++;
        if (valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pop_valid: valid=%b expected 1", valid);
        end
        if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL pop_extra: dout=%h but scoreboard empty", dout);
        end else begin
            exp = exp_q.pop_front();
            checks++;
            if (dout !== exp) begin
                errors++;
                $display("[TB] FAIL pop_data: dout=%h expected %h", dout, exp);
            end
        end
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    // Empty the scoreboard through the DUT and confirm the FIFO ends empty.
    task automatic drain_all(input string tag);
        while (exp_q.size() > 0) pop_one();
        checks++;
        if (valid !== 1'b0 || count !== '0) begin
            errors++;
            $display("[TB] FAIL %s_empty: valid=%b count=%0d expected 0/0", tag, valid, count);
        end
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        rx_data = 8'h00;
        rx_rdy  = 1'b0;
        ready   = 1'b0;
        ovr_clr = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (count !== '0 || valid !== 1'b0 || rx_rdy_clr !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: count=%0d valid=%b ack=%b ovr=%b expected 0/0/0/0",
                     count, valid, rx_rdy_clr, overrun);
        end
        rst = 1'b0;
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        checks++;
        if (count !== '0 || valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ready_when_empty: count=%0d valid=%b expected 0/0", count, valid);
        end
    endtask

    task automatic test_single_byte();
        send_byte(8'hA5, 1'b1);
        @(negedge clk);
        checks++;
        if (rx_rdy_clr !== 1'b0 || count !== 5'd1 || valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_state: ack=%b count=%0d valid=%b expected 0/1/1",
                     rx_rdy_clr, count, valid);
        end
        drain_all("single");
    endtask

    task automatic test_order_wrap();
        for (int i = 0; i < 32; i++) begin
            send_byte(8'(i), 1'b1);
            if (i % 4 == 3) repeat (4) pop_one();
        end
        checks++;
        if (overrun !== 1'b0 || count !== '0) begin
            errors++;
            $display("[TB] FAIL wrap_end: overrun=%b count=%0d expected 0/0", overrun, count);
        end
    endtask

    task automatic test_full_overrun();
        for (int i = 0; i < DEPTH; i++) send_byte(8'h10 + 8'(i), 1'b1);
        checks++;
        if (count !== 5'd16 || valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL full_count: count=%0d valid=%b expected 16/1", count, valid);
        end
        send_byte(8'hEE, 1'b0);
        checks++;
        if (overrun !== 1'b1 || count !== 5'd16) begin
            errors++;
            $display("[TB] FAIL overrun_set: overrun=%b count=%0d expected 1/16", overrun, count);
        end
    endtask

    task automatic test_overrun_clear();
        rx_data = 8'hEF;
        rx_rdy  = 1'b1;
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        checks++;
        if (overrun !== 1'b1 || rx_rdy_clr !== 1'b1 || count !== 5'd16) begin
            errors++;
            $display("[TB] FAIL set_wins: overrun=%b ack=%b count=%0d expected 1/1/16",
                     overrun, rx_rdy_clr, count);
        end
        @(negedge clk);
        rx_rdy  = 1'b0;
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovr_clear: overrun=%b expected 0", overrun);
        end
        drain_all("overrun");
    endtask

    task automatic test_full_simul_pop();
        logic [7:0] exp;
        for (int i = 0; i < DEPTH; i++) send_byte(8'h10 + 8'(i), 1'b1);
        rx_data = 8'h77;
        rx_rdy  = 1'b1;
        exp = exp_q.pop_front();
        checks++;
        if (valid !== 1'b1 || dout !== exp) begin
            errors++;
            $display("[TB] FAIL simul_head: valid=%b dout=%h expected 1/%h", valid, dout, exp);
        end
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        exp_q.push_back(8'h77);
        checks++;
        if (count !== 5'd16 || overrun !== 1'b0 || rx_rdy_clr !== 1'b1) begin
            errors++;
            $display("[TB] FAIL simul_full: count=%0d overrun=%b ack=%b expected 16/0/1",
                     count, overrun, rx_rdy_clr);
        end
        @(negedge clk);
        rx_rdy = 1'b0;
        drain_all("simul");
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 5; i++) send_byte(8'h30 + 8'(i), 1'b1);
        checks++;
        if (count !== 5'd5) begin
            errors++;
            $display("[TB] FAIL mid_fill: count=%0d expected 5", count);
        end
        rx_data = 8'h5C;
        rx_rdy  = 1'b1;
        rst     = 1'b1;
        @(negedge clk);
        checks++;
        if (count !== '0 || valid !== 1'b0 || rx_rdy_clr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset: count=%0d valid=%b ack=%b expected 0/0/0",
                     count, valid, rx_rdy_clr);
        end
        rst = 1'b0;
        exp_q.delete();
        exp_q.push_back(8'h5C);
        @(negedge clk);
        checks++;
        if (count !== 5'd1 || rx_rdy_clr !== 1'b1) begin
            errors++;
            $display("[TB] FAIL post_reset_capture: count=%0d ack=%b expected 1/1", count, rx_rdy_clr);
        end
        rx_rdy = 1'b0;
        @(negedge clk);
        checks++;
        if (count !== 5'd1 || rx_rdy_clr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_single: count=%0d ack=%b expected 1/0", count, rx_rdy_clr);
        end
        drain_all("midstream");
    endtask

    // Run every scenario back to back, then print the summary.
    initial begin
        test_reset();
        test_single_byte();
        test_order_wrap();
        test_full_overrun();
        test_overrun_clear();
        test_full_simul_pop();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
